// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// store_merge_unit : narrows SB/SH/SW stores onto a word-only data memory,
//                    using read-modify-write for byte and halfword stores.
// Revision 1.0
// ============================================================================
module store_merge_unit #(
   parameter int RD_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rd_valid,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata
);

   localparam int         c_CW    = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
   localparam logic [1:0] c_OP_SB = 2'b00;
   localparam logic [1:0] c_OP_SH = 2'b01;
   localparam logic [1:0] c_OP_SW = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_is_sh;
   logic [1:0]        r_lane;
   logic [15:0]       r_wdata;
   logic              r_err;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [c_CW-1:0]   r_cnt;
   logic [c_CW-1:0]   w_cnt_inc;
   logic              w_bad;
   logic              w_timeout;
   logic [31:0]       w_merged;

   always_comb begin
      w_bad = 1'b0;
      case (op)
         c_OP_SB: w_bad = 1'b0;
         c_OP_SH: w_bad = addr[0];
         c_OP_SW: w_bad = |addr[1:0];
         default: w_bad = 1'b1;
      endcase
   end

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (RD_TIMEOUT > 0) && (w_cnt_inc == c_CW'(RD_TIMEOUT));

   // Little-endian lane merge: only the low 8/16 bits of the store data survive.
   always_comb begin
      w_merged = mem_rdata;
      if (r_is_sh) begin
         if (r_lane[1]) w_merged[31:16] = r_wdata;
         else           w_merged[15:0]  = r_wdata;
      end else begin
         case (r_lane)
            2'd0:    w_merged[7:0]   = r_wdata[7:0];
            2'd1:    w_merged[15:8]  = r_wdata[7:0];
            2'd2:    w_merged[23:16] = r_wdata[7:0];
            default: w_merged[31:24] = r_wdata[7:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_bad)              w_next = S_DONE;
               else if (op == c_OP_SW) w_next = S_WRITE;
               else                    w_next = S_READ;
            end
         end
         S_READ:  w_next = S_WAIT;
         S_WAIT: begin
            // A response landing on the final count still wins over the timeout.
            if (mem_rd_valid)   w_next = S_WRITE;
            else if (w_timeout) w_next = S_DONE;
         end
         S_WRITE: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_is_sh     <= 1'b0;
         r_lane      <= 2'd0;
         r_wdata     <= 16'd0;
         r_err       <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_is_sh    <= (op == c_OP_SH);
                  r_lane     <= addr[1:0];
                  r_wdata    <= wdata[15:0];
                  r_err      <= w_bad;
                  r_mem_addr <= {addr[31:2], 2'b00};
                  if ((op == c_OP_SW) && !w_bad) r_mem_wdata <= wdata;
               end
            end
            S_READ: r_cnt <= '0;
            S_WAIT: begin
               if (mem_rd_valid) begin
                  r_mem_wdata <= w_merged;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_timeout) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign mem_rd_en = (r_state == S_READ);
   assign mem_wr_en = (r_state == S_WRITE);
   assign done      = (r_state == S_DONE);
   assign err       = (r_state == S_DONE) && r_err;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
// tb_store_merge_unit : vector table plus write scoreboard for store_merge_unit.
// Revision 1.0
// ============================================================================
module tb_store_merge_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_rd_valid;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   store_merge_unit #(.RD_TIMEOUT(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .op           (op),
      .addr         (addr),
      .wdata        (wdata),
      .done         (done),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_rdata    (mem_rdata),
      .mem_rd_valid (mem_rd_valid),
      .mem_wr_en    (mem_wr_en),
      .mem_wdata    (mem_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;       // cycles from read strobe to response; -1 = never
      bit          noise;     // hold mem_rd_valid high with junk outside WAIT
      bit          exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      bit          exp_err;
      int          exp_rd;
      int          exp_done;  // edges after accept at which done is sampled
   } vec_t;

   vec_t          vq[$];
   logic [63:0]   sb_q[$];

   function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int d, input bit nz, input bit ew,
                               input logic [31:0] ea, input logic [31:0] ewd, input bit ee,
                               input int erd, input int edn);
      vec_t v;
      v.op = o; v.addr = a; v.wdata = wd; v.rdata = rd; v.dly = d; v.noise = nz;
      v.exp_wr = ew; v.exp_addr = ea; v.exp_wdata = ewd; v.exp_err = ee;
      v.exp_rd = erd; v.exp_done = edn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   k_rd    = -1;
      int   n_rd    = 0;
      int   n_wr    = 0;
      int   done_at = -1;
      logic err_val = 1'b0;
      logic err_bad = 1'b0;
      logic [63:0] e;
      string tag;
      tag = $sformatf("v%0d", idx);
      chk({tag, "_ready_pre"}, {31'd0, req_ready}, 32'd1);
      if (v.exp_wr) sb_q.push_back({v.exp_addr, v.exp_wdata});
      req_valid    = 1'b1;
      op           = v.op;
      addr         = v.addr;
      wdata        = v.wdata;
      mem_rd_valid = v.noise;
      mem_rdata    = 32'hBAD0_BAD0;
      tick();
      req_valid = 1'b0;
      op        = 2'($urandom);
      addr      = $urandom;
      wdata     = $urandom;
      for (int k = 0; k < 40 && done_at < 0; k++) begin
         if (k > 0) tick();
         if (err && !done) err_bad = 1'b1;
         if (mem_rd_en) begin
            n_rd++;
            if (k_rd < 0) k_rd = k;
            chk({tag, "_rd_addr"}, mem_addr, v.exp_addr);
         end
         if (mem_wr_en) begin
            n_wr++;
            if (sb_q.size() == 0) begin
               chk({tag, "_unexpected_wr"}, 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk({tag, "_wr_addr"}, mem_addr, e[63:32]);
               chk({tag, "_wr_data"}, mem_wdata, e[31:0]);
            end
         end
         if (done) begin
            done_at = k + 1;
            err_val = err;
         end
         if (k_rd >= 0 && v.dly >= 0 && k == k_rd + v.dly) begin
            mem_rd_valid = 1'b1;
            mem_rdata    = v.rdata;
         end else begin
            mem_rd_valid = v.noise;
            mem_rdata    = 32'hBAD0_BAD0;
         end
      end
      mem_rd_valid = 1'b0;
      chk({tag, "_done_at"}, done_at, v.exp_done);
      chk({tag, "_err"}, {31'd0, err_val}, {31'd0, v.exp_err});
      chk({tag, "_n_rd"}, n_rd, v.exp_rd);
      chk({tag, "_n_wr"}, n_wr, v.exp_wr ? 32'd1 : 32'd0);
      chk({tag, "_err_gate"}, {31'd0, err_bad}, 32'd0);
      chk({tag, "_sb_empty"}, sb_q.size(), 32'd0);
      if (done_at < 0) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         sb_q.delete();
      end
      tick();
      chk({tag, "_ready_post"}, {30'd0, req_ready, done}, 32'b10);
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      op           = 2'b00;
      addr         = 32'd0;
      wdata        = 32'd0;
      mem_rdata    = 32'd0;
      mem_rd_valid = 1'b0;

      // op, addr, wdata, rdata, dly, noise, exp_wr, exp_addr, exp_wdata, exp_err, exp_rd, exp_done
      vq.push_back(mk(2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        -1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 2));
      vq.push_back(mk(2'b00, 32'h13, 32'hFFFFFFA5, 32'h11223344,  2, 0, 1, 32'h10, 32'hA5223344, 0, 1, 5));
      vq.push_back(mk(2'b00, 32'h20, 32'h00000077, 32'h11223344,  1, 0, 1, 32'h20, 32'h11223377, 0, 1, 4));
      vq.push_back(mk(2'b00, 32'h21, 32'hABCDEF01, 32'h11223344,  1, 0, 1, 32'h20, 32'h11220144, 0, 1, 4));
      vq.push_back(mk(2'b00, 32'h22, 32'h0000005A, 32'h11223344,  1, 0, 1, 32'h20, 32'h115A3344, 0, 1, 4));
      vq.push_back(mk(2'b01, 32'h06, 32'h1234BEEF, 32'hAABBCCDD,  1, 0, 1, 32'h04, 32'hBEEFCCDD, 0, 1, 4));
      vq.push_back(mk(2'b01, 32'h04, 32'h1234BEEF, 32'hAABBCCDD,  1, 0, 1, 32'h04, 32'hAABBBEEF, 0, 1, 4));
      vq.push_back(mk(2'b01, 32'h02, 32'hFFFF0000, 32'hFFFFFFFF,  2, 0, 1, 32'h00, 32'h0000FFFF, 0, 1, 5));
      vq.push_back(mk(2'b01, 32'h05, 32'h12345678, 32'h0,        -1, 1, 0, 32'h04, 32'h0,        1, 0, 1));
      vq.push_back(mk(2'b10, 32'h06, 32'h12345678, 32'h0,        -1, 1, 0, 32'h04, 32'h0,        1, 0, 1));
      vq.push_back(mk(2'b10, 32'h11, 32'h12345678, 32'h0,        -1, 0, 0, 32'h10, 32'h0,        1, 0, 1));
      vq.push_back(mk(2'b11, 32'h10, 32'h12345678, 32'h0,        -1, 1, 0, 32'h10, 32'h0,        1, 0, 1));
      vq.push_back(mk(2'b00, 32'h30, 32'h00000099, 32'h11223344, -1, 0, 0, 32'h30, 32'h0,        1, 1, 17));
      vq.push_back(mk(2'b00, 32'h31, 32'h000000C3, 32'h11223344, 15, 0, 1, 32'h30, 32'h1122C344, 0, 1, 18));
      vq.push_back(mk(2'b00, 32'h33, 32'h0000007E, 32'h11223344, 14, 0, 1, 32'h30, 32'h7E223344, 0, 1, 17));
      vq.push_back(mk(2'b10, 32'hFFFFFFFC, 32'h0, 32'h0,         -1, 1, 1, 32'hFFFFFFFC, 32'h0,  0, 0, 2));

      tick();
      tick();
      chk("rst_outputs", {27'd0, req_ready, done, err, mem_rd_en, mem_wr_en}, 32'b10000);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

      // Reset while waiting for a read response, then a stale response arrives.
      req_valid = 1'b1;
      op        = 2'b00;
      addr      = 32'h40;
      wdata     = 32'h55;
      tick();
      req_valid = 1'b0;
      chk("mid_rd_en", {31'd0, mem_rd_en}, 32'd1);
      tick();
      chk("mid_in_wait", {30'd0, req_ready, mem_rd_en}, 32'd0);
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      mem_rd_valid = 1'b1;
      mem_rdata    = 32'hCAFEF00D;
      tick();
      mem_rd_valid = 1'b0;
      chk("mid_after_rst", {28'd0, req_ready, mem_rd_en, mem_wr_en, done}, 32'b1000);
      chk("mid_addr_cleared", mem_addr, 32'd0);
      begin
         logic bad = 1'b0;
         for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_wr_en || done || mem_rd_en || !req_ready) bad = 1'b1;
         end
         chk("mid_no_strobes", {31'd0, bad}, 32'd0);
      end
      run_vec(100, mk(2'b10, 32'h44, 32'h0BADCAFE, 32'h0, -1, 0, 1, 32'h44, 32'h0BADCAFE, 0, 0, 2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
